// File: rtl/stamp_pkg.sv
// stamp_pkg: shared edge encodings and overflow counter limits for stamp_capture
package stamp_pkg;
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;
  localparam int OVF_WIDTH = 16;
  localparam logic [OVF_WIDTH-1:0] OVF_MAX = 16'hFFFF;
endpackage

// File: rtl/stamp_fifo.sv
// stamp_fifo: synchronous first-word-fall-through FIFO with flush
module stamp_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_pop, do_push;
  assign valid   = level != '0;
  assign full    = level == (AW+1)'(DEPTH);
  assign do_pop  = pop & valid;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd] : '0;
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd    <= '0;
      wr    <= '0;
      level <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/stamp_capture.sv
// stamp_capture: free-running tick counter that stamps synchronised enc_in edges into a FWFT FIFO
module stamp_capture
  import stamp_pkg::*;
#(
  parameter int CNT_WIDTH   = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic                          enc_in,
  input  logic [1:0]                    edge_sel,
  input  logic                          en,
  input  logic                          clr,
  output logic [CNT_WIDTH-1:0]          ts_now,
  output logic [CNT_WIDTH-1:0]          ts_data,
  output logic                          ts_valid,
  input  logic                          ts_pop,
  output logic [$clog2(FIFO_DEPTH):0]   ts_level,
  output logic [OVF_WIDTH-1:0]          ovf_cnt
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev, cur, rise, fall, evt, full, drop;
  // clr deliberately leaves the synchroniser alone so in-flight edges survive it
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], enc_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  assign cur  = sync[SYNC_STAGES-1];
  assign rise = cur & ~prev;
  assign fall = ~cur & prev;
  assign evt  = en & ((rise & (edge_sel == EDGE_RISE || edge_sel == EDGE_BOTH)) |
                      (fall & (edge_sel == EDGE_FALL || edge_sel == EDGE_BOTH)));
  assign drop = evt & full & ~(ts_pop & ts_valid);
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset || clr) begin
      ts_now  <= '0;
      ovf_cnt <= '0;
    end else begin
      ts_now <= ts_now + 1'b1;
      if (drop && ovf_cnt != OVF_MAX) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
  stamp_fifo #(.WIDTH(CNT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (s_axi_aclk),
    .rst   (s_axi_areset),
    .flush (clr),
    .push  (evt),
    .pop   (ts_pop),
    .din   (ts_now),
    .dout  (ts_data),
    .valid (ts_valid),
    .full  (full),
    .level (ts_level)
  );
endmodule

// File: tb/tb_stamp_capture.sv
// tb_stamp_capture: scenario tasks plus randomized traffic against a queue-based reference model
module tb_stamp_capture;
  localparam int CW = 8;
  localparam int D  = 16;
  localparam int S  = 2;
  logic clk = 0, rst = 1, enc_in = 0, en = 1, clr = 0, ts_pop = 0;
  logic [1:0] edge_sel = 2'b01;
  logic [CW-1:0] ts_now, ts_data;
  logic ts_valid;
  logic [4:0] ts_level;
  logic [15:0] ovf_cnt;
  logic [37:0] obs;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  stamp_capture #(.CNT_WIDTH(CW), .FIFO_DEPTH(D), .SYNC_STAGES(S)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .enc_in(enc_in), .edge_sel(edge_sel),
    .en(en), .clr(clr), .ts_now(ts_now), .ts_data(ts_data), .ts_valid(ts_valid),
    .ts_pop(ts_pop), .ts_level(ts_level), .ovf_cnt(ovf_cnt)
  );
  assign obs = {ts_now, ts_data, ts_valid, ts_level, ovf_cnt};
  // reference model: enc_in history as a sample queue, FIFO as a queue, counters as ints
  logic [CW-1:0] m_cnt = 0;
  logic [CW-1:0] q[$];
  int m_ovf = 0;
  logic hist[$] = '{1'b0, 1'b0, 1'b0};
  always @(posedge clk) begin : model
    logic ev, c, o;
    c = hist[S-1];
    o = hist[S];
    ev = en && ((edge_sel[0] && c && !o) || (edge_sel[1] && !c && o));
    if (rst) begin
      m_cnt = 0; q = {}; m_ovf = 0; hist = '{1'b0, 1'b0, 1'b0};
    end else begin
      hist.push_front(enc_in);
      void'(hist.pop_back());
      if (clr) begin
        m_cnt = 0; q = {}; m_ovf = 0;
      end else begin
        if (ts_pop && q.size() > 0) void'(q.pop_front());
        if (ev) begin
          if (q.size() < D) q.push_back(m_cnt);
          else if (m_ovf < 65535) m_ovf++;
        end
        m_cnt++;
      end
    end
  end
  function automatic logic [37:0] exp_v();
    logic [CW-1:0] h;
    h = q.size() > 0 ? q[0] : '0;
    return {m_cnt, h, q.size() > 0, 5'(q.size()), 16'(m_ovf)};
  endfunction
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL reset_state got=%h want=0", obs); end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (ts_now !== CW'(i + 1) || obs !== exp_v()) begin
        errs++; $display("FAIL count_up got=%h want=%h", obs, exp_v());
      end
    end
  endtask
  task automatic test_single();
    for (int n = 0; n < 300 && ts_now != 8'd100; n++) @(negedge clk);
    vecs++;
    if (ts_now !== 8'd100) begin errs++; $display("FAIL wait100 got=%0d want=100", ts_now); end
    enc_in = 1;
    repeat (3) @(negedge clk);
    vecs++;
    if (ts_valid !== 1'b1 || ts_data !== 8'd102 || obs !== exp_v()) begin
      errs++; $display("FAIL single_capture got v=%b d=%0d want v=1 d=102", ts_valid, ts_data);
    end
    ts_pop = 1;
    @(negedge clk);
    ts_pop = 0;
    vecs++;
    if (ts_valid !== 1'b0 || ts_data !== '0 || obs !== exp_v()) begin
      errs++; $display("FAIL single_pop got v=%b d=%0d want v=0 d=0", ts_valid, ts_data);
    end
  endtask
  task automatic test_burst();
    clr = 1;
    @(negedge clk);
    clr = 0;
    edge_sel = 2'b11;
    for (int t = 0; t < 20; t++) begin
      enc_in = ~enc_in;
      repeat (4) begin
        @(negedge clk);
        vecs++;
        if (obs !== exp_v()) begin errs++; $display("FAIL burst got=%h want=%h", obs, exp_v()); end
      end
    end
    repeat (3) @(negedge clk);
    vecs++;
    if (ts_level !== 5'd16 || ovf_cnt !== 16'd4) begin
      errs++; $display("FAIL burst_full got lvl=%0d ovf=%0d want lvl=16 ovf=4", ts_level, ovf_cnt);
    end
  endtask
  task automatic test_full_pop();
    logic [CW-1:0] last;
    enc_in = ~enc_in;
    repeat (2) @(negedge clk);
    ts_pop = 1;
    @(negedge clk);
    ts_pop = 0;
    vecs++;
    if (ts_level !== 5'd16 || ovf_cnt !== 16'd4 || obs !== exp_v()) begin
      errs++; $display("FAIL full_push_pop got lvl=%0d ovf=%0d want lvl=16 ovf=4", ts_level, ovf_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      last = ts_data;
      ts_pop = 1;
      @(negedge clk);
      vecs++;
      if (obs !== exp_v()) begin errs++; $display("FAIL drain got=%h want=%h", obs, exp_v()); end
      if (i < 14 && CW'(ts_data - last) !== CW'(4)) begin
        vecs++; errs++; $display("FAIL stamp_step got=%0d want=4", CW'(ts_data - last));
      end
    end
    ts_pop = 0;
  endtask
  task automatic test_wrap();
    clr = 1;
    @(negedge clk);
    clr = 0;
    for (int n = 0; n < 300 && ts_now != 8'd252; n++) @(negedge clk);
    enc_in = ~enc_in;
    for (int n = 0; n < 300 && ts_now != 8'd0; n++) @(negedge clk);
    enc_in = ~enc_in;
    repeat (3) @(negedge clk);
    vecs++;
    if (ts_level !== 5'd2 || ts_data !== 8'd254 || obs !== exp_v()) begin
      errs++; $display("FAIL wrap_first got lvl=%0d d=%0d want lvl=2 d=254", ts_level, ts_data);
    end
    ts_pop = 1;
    @(negedge clk);
    vecs++;
    if (ts_data !== 8'd2 || obs !== exp_v()) begin
      errs++; $display("FAIL wrap_second got d=%0d want d=2", ts_data);
    end
    @(negedge clk);
    ts_pop = 0;
    en = 0;
    enc_in = ~enc_in;
    repeat (5) @(negedge clk);
    vecs++;
    if (ts_level !== 5'd0 || ovf_cnt !== 16'd0 || obs !== exp_v()) begin
      errs++; $display("FAIL en_off got lvl=%0d ovf=%0d want lvl=0 ovf=0", ts_level, ovf_cnt);
    end
    en = 1;
  endtask
  task automatic test_clr();
    for (int t = 0; t < 5; t++) begin
      enc_in = ~enc_in;
      repeat (3) @(negedge clk);
    end
    vecs++;
    if (ts_level !== 5'd5 || obs !== exp_v()) begin
      errs++; $display("FAIL clr_preload got lvl=%0d want lvl=5", ts_level);
    end
    enc_in = ~enc_in;
    repeat (2) @(negedge clk);
    ts_pop = 1;
    clr = 1;
    @(negedge clk);
    ts_pop = 0;
    clr = 0;
    vecs++;
    if (ts_level !== 5'd0 || ts_now !== '0 || ovf_cnt !== '0 || obs !== exp_v()) begin
      errs++; $display("FAIL clr_priority got=%h want lvl=0 now=0 ovf=0", obs);
    end
  endtask
  task automatic test_reset_mid();
    for (int t = 0; t < 6; t++) begin
      enc_in = ~enc_in;
      repeat (2) @(negedge clk);
    end
    enc_in = ~enc_in;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    vecs++;
    if (obs !== '0 || obs !== exp_v()) begin errs++; $display("FAIL reset_mid got=%h want=0", obs); end
    rst = 0;
    @(negedge clk);
    vecs++;
    if (obs !== exp_v()) begin errs++; $display("FAIL after_reset got=%h want=%h", obs, exp_v()); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(2) == 0) enc_in = ~enc_in;
      edge_sel = 2'($urandom);
      en       = $urandom_range(3) != 0;
      ts_pop   = $urandom_range(3) == 0;
      clr      = $urandom_range(99) == 0;
      rst      = $urandom_range(499) == 0;
      @(negedge clk);
      vecs++;
      if (obs !== exp_v()) begin errs++; $display("FAIL random got=%h want=%h", obs, exp_v()); end
    end
    rst = 0; clr = 0; ts_pop = 0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_pop();
    test_wrap();
    test_clr();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
